wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Write-back stage; consumes core::mem_asm_t from mem_stage (the last pipeline register).
//  Formats load data (byte/half select, sign/zero extend), selects the rd result and drives
//  the register-file write port. Counts retired instructions; halts on ECALL/EBREAK or a
//  misaligned load. Its rdy output is the next_rdy input of mem_stage.
// PARAMETERS
//  CNT_W          64  width of retired-instruction counter instret
//  HALT_ON_SYSTEM 1   1: ECALL/EBREAK enter HALT; 0: retire as no-op, stay RUN
//  CHECK_ALIGN    1   1: misaligned LH/LHU/LW enter HALT; 0: no alignment check
// PORTS
//  clk         in   1      clock
//  rst         in   1      reset, asynchronous, active-high
//  en          in   1      stage enable
//  mem_asm     in   struct core::mem_asm_t; uses valid, pc, de_inst.{opcode,rd,funct3,imm}, ex_result, ex_addr, mem_result
//  rdy         out  1      stage accepts mem_asm this cycle (-> mem_stage.next_rdy)
//  rf_wr_en    out  1      register-file write strobe (registered)
//  rf_wr_addr  out  5      destination register
//  rf_wr_data  out  32     write data
//  instret     out  CNT_W  retired-instruction count
//  halt        out  1      core halted
//  halt_cause  out  2      0 none, 1 ECALL, 2 EBREAK, 3 misaligned load
//  halt_pc     out  32     pc of halting instruction
// BEHAVIOUR
//  Reset: all outputs 0, state RUN. rst mid-operation wipes counter, halt and pending write.
//  rdy = en && state==RUN (combinational; not gated by rst).
//  Accept: acc = rdy && mem_asm.valid. mem_stage advances only when rdy, so each packet is
//    seen once; while rdy=0 the held packet is ignored.
//  Result select on accepted packet, by opcode:
//    LOAD: a=ex_addr[1:0]; funct3 LB/LBU pick byte a, LH/LHU pick half a[1], LW full word;
//      LB/LH sign-extend, LBU/LHU zero-extend. Reserved funct3 (011,110,111) treated as LW.
//    JAL/JALR: pc+4 (32-bit, wraps). LUI/AUIPC/OP/OP-IMM: ex_result.
//    STORE/BRANCH/MISC-MEM/SYSTEM: no write.
//  Write port: registered, 1-cycle latency. Cycle after acc: rf_wr_en=1 iff writing opcode
//    && rd!=0 && not halting; rf_wr_addr=rd, rf_wr_data=result. Otherwise rf_wr_en=0;
//    addr/data hold last values.
//  Misaligned (CHECK_ALIGN=1): LH/LHU with a[0]=1, LW with a!=0 -> no write, no retire,
//    cause 3.
//  SYSTEM funct3=000 (HALT_ON_SYSTEM=1): imm[0]=0 ECALL cause 1, =1 EBREAK cause 2; retires.
//    Other SYSTEM (CSR) retire as no-op.
//  FSM: RUN --acc && halting event--> HALT (next edge: halt=1, halt_cause, halt_pc=pc).
//    HALT is terminal until rst; rdy=0, no writes, counter frozen.
//  instret: +1 on edge after each acc that retires (all except misaligned); wraps 2^CNT_W-1 -> 0.
//  mem_asm.valid=0 or en=0: no write, no count, state unchanged.
// TESTING
//  ADDI x5 result 0x0000_0123, valid -> next cycle rf_wr_en=1, addr=5, data=0x123, instret=1.
//  LB ex_addr=0x..03, mem_result=0x80FF_0000 -> data 0xFFFF_FF80; LBU same -> 0x0000_0080;
//    LHU addr 0x..02 -> 0x0000_80FF.
//  JAL rd=0 pc=0x100 -> rf_wr_en=0, instret+1; JAL rd=1 -> data 0x104.
//  LW ex_addr=0x1002 -> halt=1, cause=3, halt_pc=pc, rf_wr_en=0, instret unchanged, rdy=0 after.
//  EBREAK then ADDI held valid -> halt=1 cause=2, instret+1, ADDI never written; rst -> all 0, rdy=1.
//  en=0 with valid ADDI 3 cycles -> no writes; en=1 -> exactly one write; preload instret near
//    max (CNT_W=4), retire 2 -> wraps 15 -> 0 -> 1.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: load formatting, rd result select, register-file write port,
// retired-instruction counter and halt detection (ECALL/EBREAK/misaligned load).

package core;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } de_inst_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    de_inst_t    de_inst;
    logic [31:0] ex_result;
    logic [31:0] ex_addr;
    logic [31:0] mem_result;
  } mem_asm_t;
endpackage

module wb_stage #(
  parameter int unsigned CNT_W          = 64,
  parameter bit          HALT_ON_SYSTEM = 1'b1,
  parameter bit          CHECK_ALIGN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  core::mem_asm_t   mem_asm,
  output logic             rdy,
  output logic             rf_wr_en,
  output logic [4:0]       rf_wr_addr,
  output logic [31:0]      rf_wr_data,
  output logic [CNT_W-1:0] instret,
  output logic             halt,
  output logic [1:0]       halt_cause,
  output logic [31:0]      halt_pc
);
  import core::*;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t      state, state_next;
  logic        acc;
  logic [1:0]  a;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] result;
  logic        writes_rd;
  logic        misaligned;
  logic        sys_halt;
  logic [1:0]  cause;
  logic        unused_bits;

  assign unused_bits = ^{mem_asm.de_inst.imm[31:1], mem_asm.ex_addr[31:2]};

  assign rdy = en && (state == ST_RUN);
  assign acc = rdy && mem_asm.valid;
  assign a   = mem_asm.ex_addr[1:0];

  // Decode: load formatting, result select, halting events, next state
  always_comb begin
    byte_sel   = '0;
    half_sel   = '0;
    load_data  = '0;
    result     = '0;
    writes_rd  = 1'b0;
    misaligned = 1'b0;
    sys_halt   = 1'b0;
    cause      = '0;
    state_next = state;

    case (a)
      2'd0:    byte_sel = mem_asm.mem_result[7:0];
      2'd1:    byte_sel = mem_asm.mem_result[15:8];
      2'd2:    byte_sel = mem_asm.mem_result[23:16];
      default: byte_sel = mem_asm.mem_result[31:24];
    endcase
    half_sel = a[1] ? mem_asm.mem_result[31:16] : mem_asm.mem_result[15:0];

    // reserved funct3 encodings fall into the word case, including its alignment rule
    case (mem_asm.de_inst.funct3)
      3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100: load_data = {24'b0, byte_sel};
      3'b001: load_data = {{16{half_sel[15]}}, half_sel};
      3'b101: load_data = {16'b0, half_sel};
      default: load_data = mem_asm.mem_result;
    endcase

    case (mem_asm.de_inst.opcode)
      OPC_LOAD: begin
        result    = load_data;
        writes_rd = 1'b1;
        if (CHECK_ALIGN) begin
          case (mem_asm.de_inst.funct3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = a[0];
            default:        misaligned = (a != 2'b00);
          endcase
        end
      end
      OPC_JAL, OPC_JALR: begin
        result    = mem_asm.pc + 32'd4;
        writes_rd = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM: begin
        result    = mem_asm.ex_result;
        writes_rd = 1'b1;
      end
      OPC_SYSTEM: begin
        sys_halt = HALT_ON_SYSTEM && (mem_asm.de_inst.funct3 == 3'b000);
      end
      default: ;
    endcase

    if (misaligned)
      cause = 2'd3;
    else if (sys_halt)
      cause = mem_asm.de_inst.imm[0] ? 2'd2 : 2'd1;

    if (acc && (misaligned || sys_halt))
      state_next = ST_HALT;
  end

  // State register; HALT is left only through reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_RUN;
    else
      state <= state_next;
  end

  // Registered write port, retire counter and halt report
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      instret    <= '0;
      halt       <= 1'b0;
      halt_cause <= '0;
      halt_pc    <= '0;
    end else begin
      rf_wr_en <= 1'b0;
      if (acc) begin
        if (!misaligned)
          instret <= instret + CNT_W'(1);
        if (writes_rd && !misaligned && (mem_asm.de_inst.rd != 5'd0)) begin
          rf_wr_en   <= 1'b1;
          rf_wr_addr <= mem_asm.de_inst.rd;
          rf_wr_data <= result;
        end
        if (misaligned || sys_halt) begin
          halt       <= 1'b1;
          halt_cause <= cause;
          halt_pc    <= mem_asm.pc;
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases plus randomized packets against a reference model.
module tb_wb_stage;
  import core::*;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en  = 1'b0;
  core::mem_asm_t pkt = '0;

  logic        rdy, rf_wr_en, halt;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data, halt_pc;
  logic [63:0] instret;
  logic [1:0]  halt_cause;

  logic        rdy4, rf_wr_en4, halt4;
  logic [4:0]  rf_wr_addr4;
  logic [31:0] rf_wr_data4, halt_pc4;
  logic [3:0]  instret4;
  logic [1:0]  halt_cause4;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic        m_we, m_halt;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata, m_hpc;
  logic [63:0] m_cnt;
  logic [1:0]  m_cause;

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(64), .HALT_ON_SYSTEM(1'b1), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_asm(pkt), .rdy(rdy),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .instret(instret), .halt(halt), .halt_cause(halt_cause), .halt_pc(halt_pc)
  );

  wb_stage #(.CNT_W(4), .HALT_ON_SYSTEM(1'b1), .CHECK_ALIGN(1'b1)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mem_asm(pkt), .rdy(rdy4),
    .rf_wr_en(rf_wr_en4), .rf_wr_addr(rf_wr_addr4), .rf_wr_data(rf_wr_data4),
    .instret(instret4), .halt(halt4), .halt_cause(halt_cause4), .halt_pc(halt_pc4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] mem);
    longint unsigned b, h;
    b = (longint'(mem) >> ((addr % 4) * 8)) % 256;
    h = (longint'(mem) >> ((addr % 4) / 2 * 16)) % 65536;
    case (f3)
      3'd0:    return 32'((b >= 128) ? (b + 64'hFFFF_FF00) : b);
      3'd4:    return 32'(b);
      3'd1:    return 32'((h >= 32768) ? (h + 64'hFFFF_0000) : h);
      3'd5:    return 32'(h);
      default: return mem;
    endcase
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  task automatic model_reset();
    m_we = 0; m_halt = 0; m_waddr = 0; m_wdata = 0; m_hpc = 0; m_cnt = 0; m_cause = 0;
  endtask

  // one clock edge of the architectural behaviour
  task automatic model_step(input logic e, input core::mem_asm_t p);
    logic [6:0] op;
    bit wr;
    logic [31:0] res;
    m_we = 0;
    if (!(e && !m_halt && p.valid)) return;
    op  = p.de_inst.opcode;
    wr  = 0;
    res = 0;
    if (op == OPC_LOAD && ref_misaligned(p.de_inst.funct3, p.ex_addr)) begin
      m_halt = 1; m_cause = 3; m_hpc = p.pc;
      return;
    end
    m_cnt = m_cnt + 1;
    if (op == OPC_LOAD) begin
      wr = 1; res = ref_load(p.de_inst.funct3, p.ex_addr, p.mem_result);
    end else if (op == OPC_JAL || op == OPC_JALR) begin
      wr = 1; res = p.pc + 4;
    end else if (op == OPC_LUI || op == OPC_AUIPC || op == OPC_OP || op == OPC_OP_IMM) begin
      wr = 1; res = p.ex_result;
    end else if (op == OPC_SYSTEM && p.de_inst.funct3 == 0) begin
      m_halt = 1; m_cause = p.de_inst.imm[0] ? 2'd2 : 2'd1; m_hpc = p.pc;
    end
    if (wr && p.de_inst.rd != 0) begin
      m_we = 1; m_waddr = p.de_inst.rd; m_wdata = res;
    end
  endtask

  task automatic check_outputs();
    check("wr_en", rf_wr_en, m_we);
    check("wr_addr", rf_wr_addr, m_waddr);
    check("wr_data", rf_wr_data, m_wdata);
    check("instret", instret, m_cnt);
    check("halt", halt, m_halt);
    check("halt_cause", halt_cause, m_cause);
    check("halt_pc", halt_pc, m_hpc);
    check("instret4", instret4, m_cnt % 16);
    check("halt4", halt4, m_halt);
    check("wr_en4", rf_wr_en4, m_we);
  endtask

  // called at posedge+1: apply inputs, check rdy, step one edge, check outputs
  task automatic cycle(input logic e, input core::mem_asm_t p);
    en  = e;
    pkt = p;
    #1;
    check("rdy", rdy, e && !m_halt);
    check("rdy4", rdy4, e && !m_halt);
    model_step(e, p);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    en  = 0;
    pkt = '0;
    rst = 1;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic core::mem_asm_t mk(input logic [6:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [31:0] imm, input logic [31:0] pc,
      input logic [31:0] res, input logic [31:0] addr, input logic [31:0] mem);
    core::mem_asm_t p;
    p.valid = 1; p.pc = pc; p.de_inst.opcode = op; p.de_inst.rd = rd;
    p.de_inst.funct3 = f3; p.de_inst.imm = imm; p.ex_result = res;
    p.ex_addr = addr; p.mem_result = mem;
    return p;
  endfunction

  function automatic core::mem_asm_t rand_pkt();
    logic [6:0] ops [12];
    core::mem_asm_t p;
    ops = '{OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC,
            OPC_OP, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM, 7'b1111111};
    p = mk(ops[$urandom_range(11)], 5'($urandom_range(7) == 0 ? 0 : $urandom),
           3'($urandom), $urandom, $urandom & 32'hFFFF_FFFC, $urandom, $urandom, $urandom);
    // keep system halts and misaligned loads from dominating the run
    if (p.de_inst.opcode == OPC_SYSTEM && $urandom_range(3) != 0) p.de_inst.funct3 = 3'b001;
    if (p.de_inst.opcode == OPC_LOAD && $urandom_range(3) != 0) p.ex_addr[1:0] = 2'b00;
    p.valid = ($urandom_range(4) != 0);
    return p;
  endfunction

  initial begin
    core::mem_asm_t p;
    int halted_for;
    @(posedge clk);
    #1;
    do_reset();

    // ADDI x5
    cycle(1, mk(OPC_OP_IMM, 5, 0, 32'h123, 32'h40, 32'h123, 0, 0));
    check("addi_en", rf_wr_en, 1);
    check("addi_addr", rf_wr_addr, 5);
    check("addi_data", rf_wr_data, 32'h123);
    check("addi_instret", instret, 1);

    // load byte/half formatting
    cycle(1, mk(OPC_LOAD, 6, 3'b000, 0, 32'h44, 0, 32'h1003, 32'h80FF_0000));
    check("lb_data", rf_wr_data, 32'hFFFF_FF80);
    cycle(1, mk(OPC_LOAD, 6, 3'b100, 0, 32'h48, 0, 32'h1003, 32'h80FF_0000));
    check("lbu_data", rf_wr_data, 32'h0000_0080);
    cycle(1, mk(OPC_LOAD, 6, 3'b101, 0, 32'h4C, 0, 32'h1002, 32'h80FF_0000));
    check("lhu_data", rf_wr_data, 32'h0000_80FF);

    // JAL rd=0 / rd=1
    cycle(1, mk(OPC_JAL, 0, 0, 0, 32'h100, 0, 0, 0));
    check("jal_x0_en", rf_wr_en, 0);
    check("jal_x0_instret", instret, 5);
    cycle(1, mk(OPC_JAL, 1, 0, 0, 32'h100, 0, 0, 0));
    check("jal_data", rf_wr_data, 32'h104);
    cycle(1, mk(OPC_JALR, 2, 0, 0, 32'hFFFF_FFFC, 0, 0, 0));
    check("jalr_wrap", rf_wr_data, 32'h0);

    // misaligned LW
    cycle(1, mk(OPC_LOAD, 7, 3'b010, 0, 32'h200, 0, 32'h1002, 32'hDEAD_BEEF));
    check("mis_halt", halt, 1);
    check("mis_cause", halt_cause, 3);
    check("mis_pc", halt_pc, 32'h200);
    check("mis_en", rf_wr_en, 0);
    check("mis_instret", instret, 7);
    cycle(1, mk(OPC_OP_IMM, 5, 0, 0, 32'h204, 32'h55, 0, 0));
    check("mis_rdy", rdy, 0);
    do_reset();

    // EBREAK then ADDI held valid
    cycle(1, mk(OPC_SYSTEM, 0, 3'b000, 32'h1, 32'h300, 0, 0, 0));
    check("ebreak_cause", halt_cause, 2);
    check("ebreak_instret", instret, 1);
    for (int i = 0; i < 3; i++) cycle(1, mk(OPC_OP_IMM, 9, 0, 0, 32'h304, 32'h77, 0, 0));
    check("ebreak_nowr", rf_wr_en, 0);
    do_reset();
    check("reset_rdy", rdy, 0);
    en = 1;
    #1;
    check("reset_rdy_en", rdy, 1);

    // en=0 holds off a valid packet
    for (int i = 0; i < 3; i++) cycle(0, mk(OPC_OP_IMM, 3, 0, 0, 32'h10, 32'h9, 0, 0));
    check("en0_instret", instret, 0);
    cycle(1, mk(OPC_OP_IMM, 3, 0, 0, 32'h10, 32'h9, 0, 0));
    check("en1_write", rf_wr_en, 1);
    p = '0;
    cycle(1, p);
    check("en1_once", rf_wr_en, 0);

    // small counter wrap
    do_reset();
    for (int i = 0; i < 15; i++) cycle(1, mk(OPC_OP, 4, 0, 0, 32'h20, i, 0, 0));
    check("wrap15", instret4, 15);
    cycle(1, mk(OPC_OP, 4, 0, 0, 32'h20, 0, 0, 0));
    check("wrap0", instret4, 0);
    cycle(1, mk(OPC_OP, 4, 0, 0, 32'h20, 0, 0, 0));
    check("wrap1", instret4, 1);

    // randomized traffic
    halted_for = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_halt) halted_for++;
      if (halted_for > 3 || $urandom_range(199) == 0) begin
        do_reset();
        halted_for = 0;
      end
      cycle(($urandom_range(6) != 0), rand_pkt());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
